// File: rtl/_demux32_regbank.sv
// 32-entry register bank write port with a one-entry-per-cycle clear sweep.
// Writes land one cycle after acceptance; writes are refused while a sweep runs.
package constants;
    localparam int WORD_LENGTH = 32;
endpackage

module _demux32_regbank #(
    parameter int n        = constants::WORD_LENGTH,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [4:0]   wr_sel,
    input  logic [n-1:0] wr_data,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic [n-1:0] out00, out01, out02, out03, out04, out05, out06, out07,
    output logic [n-1:0] out08, out09, out10, out11, out12, out13, out14, out15,
    output logic [n-1:0] out16, out17, out18, out19, out20, out21, out22, out23,
    output logic [n-1:0] out24, out25, out26, out27, out28, out29, out30, out31
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state, state_nxt;
    logic [4:0]     cnt, cnt_nxt;
    logic           wr_en;
    logic [n-1:0]   bank [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 5'd0;
                end
            end
            CLEAR: begin
                // 5-bit increment wraps 31 -> 0 exactly as the sweep finishes
                cnt_nxt = cnt + 5'd1;
                if (cnt == 5'd31) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_ready = (state == IDLE);
    assign clr_busy = (state == CLEAR);

    // Entry 0 writes complete the handshake but are dropped when it is the zero register
    assign wr_en = wr_valid && wr_ready && !((ZERO_REG != 0) && (wr_sel == 5'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) bank[i] <= '0;
        end else begin
            if (wr_en)    bank[wr_sel] <= wr_data;
            if (clr_busy) bank[cnt]    <= '0;
        end
    end

    assign out00 = bank[0];
    assign out01 = bank[1];
    assign out02 = bank[2];
    assign out03 = bank[3];
    assign out04 = bank[4];
    assign out05 = bank[5];
    assign out06 = bank[6];
    assign out07 = bank[7];
    assign out08 = bank[8];
    assign out09 = bank[9];
    assign out10 = bank[10];
    assign out11 = bank[11];
    assign out12 = bank[12];
    assign out13 = bank[13];
    assign out14 = bank[14];
    assign out15 = bank[15];
    assign out16 = bank[16];
    assign out17 = bank[17];
    assign out18 = bank[18];
    assign out19 = bank[19];
    assign out20 = bank[20];
    assign out21 = bank[21];
    assign out22 = bank[22];
    assign out23 = bank[23];
    assign out24 = bank[24];
    assign out25 = bank[25];
    assign out26 = bank[26];
    assign out27 = bank[27];
    assign out28 = bank[28];
    assign out29 = bank[29];
    assign out30 = bank[30];
    assign out31 = bank[31];

endmodule

// File: tb/tb__demux32_regbank.sv
// Bench for _demux32_regbank: two instances (zero register on/off) against a behavioural bank model.
module tb__demux32_regbank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_sel = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        clr_req = 1'b0;
    logic        rdy_a, busy_a, rdy_b, busy_b;
    logic [31:0] oa [32];
    logic [31:0] ob [32];

    int errs = 0;
    int checks = 0;

    // model: entry contents plus number of sweep cycles still to run
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    int          busy_left = 0;

    always #5 clk = ~clk;

    _demux32_regbank #(.n(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy_a), .wr_sel(wr_sel),
        .wr_data(wr_data), .clr_req(clr_req), .clr_busy(busy_a),
        .out00(oa[0]),  .out01(oa[1]),  .out02(oa[2]),  .out03(oa[3]),  .out04(oa[4]),  .out05(oa[5]),  .out06(oa[6]),  .out07(oa[7]),
        .out08(oa[8]),  .out09(oa[9]),  .out10(oa[10]), .out11(oa[11]), .out12(oa[12]), .out13(oa[13]), .out14(oa[14]), .out15(oa[15]),
        .out16(oa[16]), .out17(oa[17]), .out18(oa[18]), .out19(oa[19]), .out20(oa[20]), .out21(oa[21]), .out22(oa[22]), .out23(oa[23]),
        .out24(oa[24]), .out25(oa[25]), .out26(oa[26]), .out27(oa[27]), .out28(oa[28]), .out29(oa[29]), .out30(oa[30]), .out31(oa[31])
    );

    _demux32_regbank #(.n(32), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy_b), .wr_sel(wr_sel),
        .wr_data(wr_data), .clr_req(clr_req), .clr_busy(busy_b),
        .out00(ob[0]),  .out01(ob[1]),  .out02(ob[2]),  .out03(ob[3]),  .out04(ob[4]),  .out05(ob[5]),  .out06(ob[6]),  .out07(ob[7]),
        .out08(ob[8]),  .out09(ob[9]),  .out10(ob[10]), .out11(ob[11]), .out12(ob[12]), .out13(ob[13]), .out14(ob[14]), .out15(ob[15]),
        .out16(ob[16]), .out17(ob[17]), .out18(ob[18]), .out19(ob[19]), .out20(ob[20]), .out21(ob[21]), .out22(ob[22]), .out23(ob[23]),
        .out24(ob[24]), .out25(ob[25]), .out26(ob[26]), .out27(ob[27]), .out28(ob[28]), .out29(ob[29]), .out30(ob[30]), .out31(ob[31])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ma[i] = 32'd0;
            mb[i] = 32'd0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ma[i] = 32'd0;
                mb[i] = 32'd0;
            end
            busy_left = 0;
        end else if (busy_left > 0) begin
            ma[32 - busy_left] = 32'd0;
            mb[32 - busy_left] = 32'd0;
            busy_left--;
        end else begin
            if (wr_valid) begin
                if (wr_sel != 5'd0) ma[wr_sel] = wr_data;
                mb[wr_sel] = wr_data;
            end
            if (clr_req) busy_left = 32;
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("zr1_out%0d", i), oa[i], ma[i]);
            chk($sformatf("zr0_out%0d", i), ob[i], mb[i]);
        end
        chk("zr1_wr_ready", {31'd0, rdy_a}, {31'd0, busy_left == 0});
        chk("zr1_clr_busy", {31'd0, busy_a}, {31'd0, busy_left != 0});
        chk("zr0_wr_ready", {31'd0, rdy_b}, {31'd0, busy_left == 0});
        chk("zr0_clr_busy", {31'd0, busy_b}, {31'd0, busy_left != 0});
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // counts negedges with clr_busy high; mid_pulse>=0 pulses clr_req at that count
    task automatic count_sweep(input int mid_pulse, input int stop_at, output int n);
        n = 0;
        while (busy_a && n < 100 && n != stop_at) begin
            n++;
            if (n == 10) begin
                chk("sweep_mid_out8_cleared", oa[8], 32'd0);
            end
            clr_req = (n == mid_pulse);
            tick();
        end
        clr_req = 1'b0;
    endtask

    int n;

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_out05", oa[5], 32'd0);
        chk("reset_out31", ob[31], 32'd0);
        chk("reset_wr_ready", {31'd0, rdy_a}, 32'd1);
        chk("reset_clr_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // single write
        wr_valid = 1'b1; wr_sel = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_valid = 1'b0;
        chk("write_out05", oa[5], 32'hDEADBEEF);
        chk("write_out04", oa[4], 32'd0);

        // back-to-back writes
        for (int i = 1; i <= 3; i++) begin
            wr_valid = 1'b1; wr_sel = 5'(i); wr_data = 32'h100 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("b2b_out01", oa[1], 32'h101);
        chk("b2b_out03", oa[3], 32'h103);

        // zero register on/off
        wr_valid = 1'b1; wr_sel = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_valid = 1'b0;
        chk("zero_reg_on_out00", oa[0], 32'd0);
        chk("zero_reg_off_out00", ob[0], 32'hFFFFFFFF);

        // fill with index+1, sweep, write held through the sweep
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_sel = 5'(i); wr_data = 32'(i + 1);
            tick();
        end
        wr_valid = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_sel = 5'd7; wr_data = 32'h77;
        chk("sweep_start_ready", {31'd0, rdy_a}, 32'd0);
        chk("sweep_start_out09", oa[9], 32'd10);
        count_sweep(-1, -1, n);
        chk("sweep_length", 32'(n), 32'd32);
        chk("sweep_end_out30", oa[30], 32'd0);
        tick();
        wr_valid = 1'b0;
        chk("held_write_out07", oa[7], 32'h77);

        // write and clear at the same edge, with a mid-sweep clr_req pulse
        wr_valid = 1'b1; wr_sel = 5'd31; wr_data = 32'hA5A5A5A5; clr_req = 1'b1;
        tick();
        wr_valid = 1'b0; clr_req = 1'b0;
        chk("simul_out31_written", oa[31], 32'hA5A5A5A5);
        count_sweep(5, -1, n);
        chk("simul_sweep_length", 32'(n), 32'd32);
        chk("simul_out31_cleared", oa[31], 32'd0);

        // reset during sweep
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_sel = 5'(i); wr_data = 32'hC000 + 32'(i);
            tick();
        end
        wr_valid = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_sweep(-1, 10, n);
        #2 rst = 1'b1;
        #1;
        chk("midsweep_rst_out20", oa[20], 32'd0);
        chk("midsweep_rst_ready", {31'd0, rdy_a}, 32'd1);
        chk("midsweep_rst_busy", {31'd0, busy_a}, 32'd0);
        tick();
        rst = 1'b0;
        wr_valid = 1'b1; wr_sel = 5'd3; wr_data = 32'h33;
        tick();
        wr_valid = 1'b0;
        chk("post_rst_write_out03", oa[3], 32'h33);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_sel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wr_data  = $urandom;
            clr_req  = ($urandom_range(0, 59) == 0);
            tick();
        end
        wr_valid = 1'b0; clr_req = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
